// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_code_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;

  // Odd parity over data plus parity bit: true when the frame is consistent.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_pin_filter.sv
// Two-flop synchroniser followed by a hold-time debounce for one PS/2 pin.
module ps2_pin_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o
);

  localparam int unsigned CntW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ps2_code_rx.sv
// PS/2 keyboard receiver: frame FSM, E0/F0 prefix folding and a show-ahead record FIFO.
// Optional frame timeout is compiled in with `define PS2_RX_TIMEOUT_EN.
module ps2_code_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] code_byte,
  output logic       code_ext,
  output logic       code_brk,
  output logic       parity_err,
  output logic       frame_err,
  output logic       ovf
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned PtrW     = AW + 1;
  localparam int unsigned DataBits = PS2_FRAME_BITS - 3;

  logic fclk, fdata, fclk_q, fall;

  ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (ps2_clk),
    .level_o(fclk)
  );

  ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (ps2_data),
    .level_o(fdata)
  );

  assign fall = fclk_q & ~fclk;

  ps2_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       byte_ok_q, byte_ok_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_ok_d = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!fdata) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {fdata, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(DataBits - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = fdata;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!fdata) begin
            ferr_d = 1'b1;
          end else if (!ps2_parity_ok(shift_q, par_q)) begin
            perr_d = 1'b1;
          end else begin
            byte_ok_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_RX_TIMEOUT_EN
    tmo_cnt_d = '0;
    if (state_q != IDLE && !fall) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        ferr_d    = 1'b1;
        tmo_cnt_d = '0;
      end
    end
`endif
  end

  // The byte is still held in shift_q in the cycle after STOP, so no extra copy.
  logic      ext_q, ext_d, brk_q, brk_d;
  logic      push;
  ps2_code_t rec;

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    rec   = '{ext: ext_q, brk: brk_q, code: shift_q};
    if (perr_q || ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_ok_q) begin
      if (shift_q == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  ps2_code_t           mem_q [DEPTH];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic                full, empty, pop, wr_en, ovf_q, ovf_d;
  ps2_code_t           head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & code_ready;
  assign wr_en = push & (~full | pop);
  assign ovf_d = push & full & ~pop;
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wptr_q[AW-1:0]] <= rec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fclk_q    <= 1'b1;
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      byte_ok_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      fclk_q    <= fclk;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      byte_ok_q <= byte_ok_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      wptr_q    <= wptr_q + PtrW'(wr_en);
      rptr_q    <= rptr_q + PtrW'(pop);
      ovf_q     <= ovf_d;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign code_valid = ~empty;
  assign code_byte  = empty ? 8'h00 : head.code;
  assign code_ext   = ~empty & head.ext;
  assign code_brk   = ~empty & head.brk;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign ovf        = ovf_q;

endmodule
